// File: rtl/rom_dl_bridge.sv
// Byte-to-word bridge from the ROM downloader to the two sdram write ports.
// Pairs download bytes into words, queues them and issues toggle req/ack writes.
module rom_dl_bridge #(
  parameter logic [23:0] SP_BASE    = 24'h00C000,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ioctl_downl,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic        port1_req,
  input  logic        port1_ack,
  output logic [22:0] port1_a,
  output logic [1:0]  port1_ds,
  output logic [15:0] port1_d,
  output logic        port2_req,
  input  logic        port2_ack,
  output logic [22:0] port2_a,
  output logic [1:0]  port2_ds,
  output logic [15:0] port2_d,
  output logic        rom_loaded,
  output logic        core_reset,
  output logic        overflow
);

  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = PW + 1;

  typedef struct packed {
    logic        sel;
    logic [22:0] a;
    logic [1:0]  ds;
    logic [15:0] d;
  } entry_t;

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  logic          r_wr_d, r_dl_d, r_dl_seen;
  logic          r_pend_v;
  logic [22:0]   r_pend_a;
  logic [7:0]    r_pend_d;
  entry_t        r_mem [FIFO_DEPTH];
  logic [PW-1:0] r_wptr, r_rptr;
  logic [CW-1:0] r_cnt;
  state_t        r_state;
  logic          r_sel;
  logic          r_p1_req, r_p2_req;
  logic [22:0]   r_p1_a, r_p2_a;
  logic [1:0]    r_p1_ds, r_p2_ds;
  logic [15:0]   r_p1_d, r_p2_d;
  logic          r_rom_loaded, r_core_reset, r_overflow;

  logic [23:0]   w_baddr;
  logic          w_ev, w_dl_fall, w_dl_rise;
  entry_t        w_flush, w_new11, w_new10, w_p0, w_p1, w_head;
  logic          w_p0_v, w_p1_v;
  logic          w_pend_v_nx;
  logic [22:0]   w_pend_a_nx;
  logic [7:0]    w_pend_d_nx;
  logic          w_pop, w_acc0, w_acc1, w_drop;
  logic [CW-1:0] w_space, w_nacc;
  logic          w_unused;

  assign w_unused  = ioctl_addr[24];
  assign w_baddr   = ioctl_addr[23:0];
  assign w_ev      = ioctl_wr & ~r_wr_d;
  assign w_dl_fall = r_dl_d & ~ioctl_downl;
  assign w_dl_rise = ~r_dl_d & ioctl_downl;

  // Candidate entries: pending even byte alone, a full pair, or a lone odd byte
  assign w_flush.sel = {r_pend_a, 1'b0} >= SP_BASE;
  assign w_flush.a   = r_pend_a;
  assign w_flush.ds  = 2'b01;
  assign w_flush.d   = {8'h00, r_pend_d};
  assign w_new11.sel = w_baddr >= SP_BASE;
  assign w_new11.a   = w_baddr[23:1];
  assign w_new11.ds  = 2'b11;
  assign w_new11.d   = {ioctl_dout, r_pend_d};
  assign w_new10.sel = w_baddr >= SP_BASE;
  assign w_new10.a   = w_baddr[23:1];
  assign w_new10.ds  = 2'b10;
  assign w_new10.d   = {ioctl_dout, 8'h00};

  // Pairing: up to two pushes (w_p0 then w_p1) per byte event
  always_comb begin
    w_p0        = '0;
    w_p1        = '0;
    w_p0_v      = 1'b0;
    w_p1_v      = 1'b0;
    w_pend_v_nx = r_pend_v;
    w_pend_a_nx = r_pend_a;
    w_pend_d_nx = r_pend_d;
    if (w_ev) begin
      if (!w_baddr[0]) begin
        if (r_pend_v) begin
          w_p0_v = 1'b1;
          w_p0   = w_flush;
        end
        w_pend_v_nx = 1'b1;
        w_pend_a_nx = w_baddr[23:1];
        w_pend_d_nx = ioctl_dout;
      end else if (r_pend_v && (r_pend_a == w_baddr[23:1])) begin
        w_p0_v      = 1'b1;
        w_p0        = w_new11;
        w_pend_v_nx = 1'b0;
      end else begin
        w_pend_v_nx = 1'b0;
        w_p0_v      = 1'b1;
        if (r_pend_v) begin
          w_p0   = w_flush;
          w_p1_v = 1'b1;
          w_p1   = w_new10;
        end else begin
          w_p0   = w_new10;
        end
      end
    end else if (w_dl_fall && r_pend_v) begin
      w_p0_v      = 1'b1;
      w_p0        = w_flush;
      w_pend_v_nx = 1'b0;
    end
  end

  // Free slots this cycle count a same-cycle pop, so push-while-full-with-pop is kept
  assign w_head  = r_mem[r_rptr];
  assign w_pop   = (r_state == S_IDLE) && (r_cnt != '0);
  assign w_space = CW'(FIFO_DEPTH) - r_cnt + CW'(w_pop);
  assign w_acc0  = w_p0_v && (w_space != '0);
  assign w_acc1  = w_p1_v && (w_space >= CW'(2));
  assign w_drop  = (w_p0_v & ~w_acc0) | (w_p1_v & ~w_acc1);
  assign w_nacc  = CW'(w_acc0) + CW'(w_acc1);

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_pend_v <= 1'b0;
      r_pend_a <= '0;
      r_pend_d <= '0;
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_cnt    <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
    end else begin
      r_pend_v <= w_pend_v_nx;
      r_pend_a <= w_pend_a_nx;
      r_pend_d <= w_pend_d_nx;
      if (w_acc0) r_mem[r_wptr] <= w_p0;
      if (w_acc1) r_mem[r_wptr + PW'(1)] <= w_p1;
      r_wptr <= r_wptr + PW'(w_nacc);
      if (w_pop) r_rptr <= r_rptr + PW'(1);
      r_cnt <= r_cnt + w_nacc - CW'(w_pop);
    end
  end

  // Issuer: one outstanding request across both ports
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= S_IDLE;
      r_sel    <= 1'b0;
      r_p1_req <= 1'b0;
      r_p1_a   <= '0;
      r_p1_ds  <= '0;
      r_p1_d   <= '0;
      r_p2_req <= 1'b0;
      r_p2_a   <= '0;
      r_p2_ds  <= '0;
      r_p2_d   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_sel   <= w_head.sel;
            r_state <= S_WAIT;
            if (w_head.sel) begin
              r_p2_a   <= w_head.a;
              r_p2_ds  <= w_head.ds;
              r_p2_d   <= w_head.d;
              r_p2_req <= ~r_p2_req;
            end else begin
              r_p1_a   <= w_head.a;
              r_p1_ds  <= w_head.ds;
              r_p1_d   <= w_head.d;
              r_p1_req <= ~r_p1_req;
            end
          end
        end
        S_WAIT: begin
          if (r_sel ? (port2_ack == r_p2_req) : (port1_ack == r_p1_req))
            r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Download status, loaded flag and derived core reset
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_d       <= 1'b0;
      r_dl_d       <= 1'b0;
      r_dl_seen    <= 1'b0;
      r_rom_loaded <= 1'b0;
      r_core_reset <= 1'b1;
      r_overflow   <= 1'b0;
    end else begin
      r_wr_d       <= ioctl_wr;
      r_dl_d       <= ioctl_downl;
      r_dl_seen    <= r_dl_seen | ioctl_downl;
      r_core_reset <= ioctl_downl | ~r_rom_loaded;
      if (!ioctl_downl && r_dl_seen && !r_pend_v && (r_cnt == '0) && (r_state == S_IDLE))
        r_rom_loaded <= 1'b1;
      if (w_dl_rise)   r_overflow <= 1'b0;
      else if (w_drop) r_overflow <= 1'b1;
    end
  end

  assign port1_req  = r_p1_req;
  assign port1_a    = r_p1_a;
  assign port1_ds   = r_p1_ds;
  assign port1_d    = r_p1_d;
  assign port2_req  = r_p2_req;
  assign port2_a    = r_p2_a;
  assign port2_ds   = r_p2_ds;
  assign port2_d    = r_p2_d;
  assign rom_loaded = r_rom_loaded;
  assign core_reset = r_core_reset;
  assign overflow   = r_overflow;

endmodule

// File: tb/tb_rom_dl_bridge.sv
// Directed bench for rom_dl_bridge: sdram ack responder plus a write scoreboard.
module tb_rom_dl_bridge;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic        ioctl_downl, ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        port1_req, port1_ack, port2_req, port2_ack;
  logic [22:0] port1_a, port2_a;
  logic [1:0]  port1_ds, port2_ds;
  logic [15:0] port1_d, port2_d;
  logic        rom_loaded, core_reset, overflow;

  always #5 clk_sys = ~clk_sys;

  rom_dl_bridge dut (
    .clk_sys(clk_sys), .reset_n(reset_n),
    .ioctl_downl(ioctl_downl), .ioctl_wr(ioctl_wr),
    .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
    .port1_req(port1_req), .port1_ack(port1_ack), .port1_a(port1_a),
    .port1_ds(port1_ds), .port1_d(port1_d),
    .port2_req(port2_req), .port2_ack(port2_ack), .port2_a(port2_a),
    .port2_ds(port2_ds), .port2_d(port2_d),
    .rom_loaded(rom_loaded), .core_reset(core_reset), .overflow(overflow)
  );

  int          n_chk = 0;
  int          n_pass = 0;
  int          n_wr = 0;
  logic [41:0] sb_q[$];
  logic        hold = 1'b0;
  logic        prev1 = 1'b0;
  logic        prev2 = 1'b0;
  int          c1 = 0;
  int          c2 = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic logic [41:0] exp_w(input logic port, input logic [23:0] baddr,
                                        input logic [1:0] ds, input logic [15:0] d);
    return {port, baddr[23:1], ds, d};
  endfunction

  function automatic logic [41:0] pop_exp();
    if (sb_q.size() > 0) return sb_q.pop_front();
    return '1;
  endfunction

  // sdram responder: echoes req on ack three cycles later unless held off
  always @(negedge clk_sys) begin
    if (!reset_n) begin
      port1_ack = 1'b0;
      port2_ack = 1'b0;
      c1 = 0;
      c2 = 0;
    end else if (!hold) begin
      if (port1_req !== port1_ack) begin
        c1++;
        if (c1 >= 3) begin port1_ack = port1_req; c1 = 0; end
      end
      if (port2_req !== port2_ack) begin
        c2++;
        if (c2 >= 3) begin port2_ack = port2_req; c2 = 0; end
      end
    end
  end

  // Every req toggle is one sdram write, checked against the scoreboard head
  always @(negedge clk_sys) begin
    if (reset_n === 1'b1) begin
      if (port1_req !== prev1) begin
        n_wr++;
        chk("port1_write", {1'b0, port1_a, port1_ds, port1_d}, pop_exp());
      end
      if (port2_req !== prev2) begin
        n_wr++;
        chk("port2_write", {1'b1, port2_a, port2_ds, port2_d}, pop_exp());
      end
    end
    prev1 = port1_req;
    prev2 = port2_req;
  end

  task automatic send_held(input logic [23:0] a, input logic [7:0] d, input int n);
    ioctl_addr = 25'(a);
    ioctl_dout = d;
    ioctl_wr   = 1'b1;
    repeat (n) @(negedge clk_sys);
    ioctl_wr   = 1'b0;
    @(negedge clk_sys);
  endtask

  task automatic send(input logic [23:0] a, input logic [7:0] d);
    send_held(a, d, 1);
  endtask

  task automatic wait_idle(input int max);
    int i = 0;
    while (i < max && !(sb_q.size() == 0 && port1_req === port1_ack && port2_req === port2_ack)) begin
      @(negedge clk_sys);
      i++;
    end
    chk("idle_wait", 64'(sb_q.size() == 0 && port1_req === port1_ack && port2_req === port2_ack), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int i;
    reset_n = 1'b0; ioctl_downl = 1'b0; ioctl_wr = 1'b0; ioctl_addr = '0; ioctl_dout = '0;
    repeat (3) @(negedge clk_sys);
    chk("rst_p1_req", port1_req, 0);
    chk("rst_p2_req", port2_req, 0);
    chk("rst_p1_d", port1_d, 0);
    chk("rst_rom_loaded", rom_loaded, 0);
    chk("rst_core_reset", core_reset, 1);
    chk("rst_overflow", overflow, 0);
    reset_n = 1'b1;
    @(negedge clk_sys);
    ioctl_downl = 1'b1;
    @(negedge clk_sys);

    // Pair at 0/1 with latency check on the completing event
    send(24'h0, 8'h11);
    chk("t1_even_only", port1_req, 0);
    sb_q.push_back(exp_w(1'b0, 24'h0, 2'b11, 16'h2211));
    ioctl_addr = 25'h1; ioctl_dout = 8'h22; ioctl_wr = 1'b1;
    @(negedge clk_sys);
    ioctl_wr = 1'b0;
    chk("t1_lat_n1", port1_req, 0);
    @(negedge clk_sys);
    chk("t1_lat_n2", port1_req, 1);
    wait_idle(50);

    // Sprite region goes to port 2
    sb_q.push_back(exp_w(1'b1, 24'h00C000, 2'b11, 16'hBBAA));
    send(24'h00C000, 8'hAA);
    send(24'h00C001, 8'hBB);
    wait_idle(50);
    chk("t2_p1_req", port1_req, 1);
    chk("t2_p2_req", port2_req, 1);

    // Strobe held high five cycles is a single byte
    sb_q.push_back(exp_w(1'b0, 24'h2, 2'b11, 16'h4433));
    send_held(24'h2, 8'h33, 5);
    send(24'h3, 8'h44);
    wait_idle(50);
    chk("t5_writes", n_wr, 3);

    // Lone odd byte, then even/odd of different words
    sb_q.push_back(exp_w(1'b0, 24'h0B, 2'b10, 16'h7700));
    send(24'h0B, 8'h77);
    wait_idle(50);
    sb_q.push_back(exp_w(1'b0, 24'h0C, 2'b01, 16'h0012));
    sb_q.push_back(exp_w(1'b0, 24'h0F, 2'b10, 16'h3400));
    send(24'h0C, 8'h12);
    send(24'h0F, 8'h34);
    wait_idle(50);
    chk("mix_writes", n_wr, 6);

    // Lone even byte flushed by end of download
    sb_q.push_back(exp_w(1'b0, 24'h4, 2'b01, 16'h005A));
    send(24'h4, 8'h5A);
    @(negedge clk_sys);
    chk("t3_pend_held", n_wr, 6);
    ioctl_downl = 1'b0;
    @(negedge clk_sys);
    @(negedge clk_sys);
    chk("t3_rom_not_yet", rom_loaded, 0);
    i = 0;
    while (i < 50 && rom_loaded !== 1'b1) begin @(negedge clk_sys); i++; end
    chk("t3_rom_loaded", rom_loaded, 1);
    chk("t3_flushed", sb_q.size(), 0);
    chk("t3_core_reset_hold", core_reset, 1);
    @(negedge clk_sys);
    chk("t3_core_reset_drop", core_reset, 0);

    // Six words against a held ack: five written, one dropped
    ioctl_downl = 1'b1;
    @(negedge clk_sys);
    chk("ovf_clear", overflow, 0);
    chk("core_reset_dl", core_reset, 1);
    hold = 1'b1;
    for (int k = 0; k < 6; k++) begin
      if (k < 5) sb_q.push_back(exp_w(1'b0, 24'(24'h20 + 2 * k), 2'b11,
                                      {8'(8'h80 + k), 8'(8'h40 + k)}));
      send(24'(24'h20 + 2 * k), 8'(8'h40 + k));
      send(24'(24'h21 + 2 * k), 8'(8'h80 + k));
    end
    chk("ovf_set", overflow, 1);
    chk("ovf_in_flight", n_wr, 8);
    hold = 1'b0;
    wait_idle(300);
    chk("ovf_written", n_wr, 12);
    chk("ovf_sticky", overflow, 1);
    chk("rom_stays", rom_loaded, 1);

    // Reset with one request outstanding and two words queued
    hold = 1'b1;
    sb_q.push_back(exp_w(1'b0, 24'h40, 2'b11, 16'h9190));
    for (int k = 0; k < 3; k++) begin
      send(24'(24'h40 + 2 * k), 8'(8'h90 + 2 * k));
      send(24'(24'h41 + 2 * k), 8'(8'h91 + 2 * k));
    end
    chk("rst_pre_writes", n_wr, 13);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_p1_req", port1_req, 0);
    chk("arst_p1_a", port1_a, 0);
    chk("arst_p1_ds", port1_ds, 0);
    chk("arst_p1_d", port1_d, 0);
    chk("arst_p2_a", port2_a, 0);
    chk("arst_p2_d", port2_d, 0);
    chk("arst_overflow", overflow, 0);
    chk("arst_rom_loaded", rom_loaded, 0);
    chk("arst_core_reset", core_reset, 1);
    @(negedge clk_sys);
    @(negedge clk_sys);
    reset_n = 1'b1;
    hold = 1'b0;
    repeat (30) @(negedge clk_sys);
    chk("post_rst_writes", n_wr, 13);
    chk("post_rst_p1_req", port1_req, 0);
    chk("post_rst_core_reset", core_reset, 1);
    chk("sb_drained", sb_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/rom_dl_bridge.md
# rom_dl_bridge

Byte-to-word bridge between the SPI ROM downloader (`data_io`) and the two write ports of the arcade `sdram` controller. It pairs consecutive download bytes into 16-bit words and buffers them in a small FIFO. Each word is routed to port 1 (CPU, fg and bg ROMs) or port 2 (sprite graphics) by address and issued with the toggle req/ack handshake. The block also owns the `rom_loaded` flag and the core reset derived from download state.

## Interface
- `SP_BASE`, default 24'h00C000: first byte address routed to port 2; lower addresses go to port 1.
- `FIFO_DEPTH`, default 4: word FIFO entries; must be a power of two.
- `clk_sys` in 1: system clock (18 MHz); all logic on its rising edge.
- `reset_n` in 1: reset, asynchronous, active-low.
- `ioctl_downl` in 1: download active.
- `ioctl_wr` in 1: byte strobe; level, may be high for several cycles.
- `ioctl_addr` in 25: byte address; bits [23:0] are used.
- `ioctl_dout` in 8: byte data.
- `port1_req` out 1: toggled once per port-1 write.
- `port1_ack` in 1: equals `port1_req` when the write is done.
- `port1_a` out 23: word address.
- `port1_ds` out 2: byte enables; bit 0 = low (even) byte.
- `port1_d` out 16: {odd byte, even byte}.
- `port2_req`, `port2_ack`, `port2_a`, `port2_ds`, `port2_d`: same as the port-1 signals, for port 2.
- `rom_loaded` out 1: set after the first complete download.
- `core_reset` out 1: `ioctl_downl | ~rom_loaded`; registered.
- `overflow` out 1: sticky; set when a word is dropped.

## Operation
- Edge detect: `wr_d` holds the registered `ioctl_wr`. A byte event is `ioctl_wr & ~wr_d`. Only one event is taken per high period.
- Pairing register `pend` holds {valid, word addr, even byte}.
  - Even byte, `pend` empty: store it; nothing is pushed.
  - Odd byte whose word addr equals `pend` addr: push {addr, ds=11, d={odd, pend byte}} and clear `pend`.
  - Odd byte, `pend` empty or a different addr: first flush `pend` if valid. Then push {addr, ds=10, d={odd, 8'h00}}.
  - Even byte while `pend` is valid: push `pend` as ds=01 with d={8'h00, byte}, then store the new byte.
  - Falling edge of `ioctl_downl`: flush `pend` if valid (ds=01).
- A single event that needs two pushes uses a 2-entry staging path. The block still accepts one event per cycle.
- Port select is fixed at push time: `sel = byte addr >= SP_BASE`. It is stored in the entry.
- Issuer states:
  - IDLE: FIFO not empty → pop, drive the selected port's a/ds/d registers, toggle its req, go to WAIT.
  - WAIT: stay until the selected ack equals its req, then go to IDLE.
  - Only one request is outstanding across both ports.
  - The unselected port's a/ds/d and req hold their values.
- Overflow: a push into a full FIFO without a pop that cycle drops the word and sets `overflow`. `overflow` clears on the rising edge of `ioctl_downl`.
- `rom_loaded` sets when all of the following hold: `ioctl_downl` is low, a download has started since reset, `pend` is empty, the FIFO is empty, and the issuer is in IDLE. It never clears except on reset.

## Timing
- Reset values:
  - req, a, ds, d, `rom_loaded`, `overflow`, `pend`, FIFO: all 0.
  - Issuer: IDLE.
  - `core_reset`: 1.
- Latency: an event detected in cycle N that completes a word causes the req toggle to appear at cycle N+2, provided the FIFO was empty and the issuer idle.
- Push and pop in the same cycle is legal; the count is unchanged. A push while full plus a pop in that cycle is accepted.
- An ack that toggles back in the same cycle the request is issued is not seen until WAIT.
- Reset mid-transfer abandons all entries and the outstanding request. `sdram` must be reset together with this block, so ack=req=0 after reset.
- FIFO pointers wrap modulo `FIFO_DEPTH`.

## Test plan
- Download bytes 0x11@0 and 0x22@1, ack echoing req after 3 cycles → `port1_a`=0, `port1_ds`=11, `port1_d`=0x2211, one `port1_req` toggle, 2 cycles after the second event.
- Bytes 0xAA@0xC000 and 0xBB@0xC001 → port 2 toggles once with `a`=0x6000, `d`=0xBBAA; `port1_req` unchanged.
- Lone byte 0x5A@4, then `ioctl_downl` falls → flushed as `port1_a`=2, `ds`=01, `d`=0x005A; `rom_loaded` rises after the ack; `core_reset` drops one cycle later.
- Ack held off while 6 words stream in (`FIFO_DEPTH`=4) → `overflow`=1; exactly the first 5 words (1 in flight plus 4 queued) are written, in order.
- `ioctl_wr` held high for 5 cycles → exactly one byte event.
- `reset_n` pulled low with an outstanding request and 2 words queued → all outputs return to reset values asynchronously; no further req toggles; `core_reset`=1.
